// File: rtl/store_log_fifo.sv
// Store-bus logger: captures each data-memory store {addr, data, flags} into a
// first-word-fall-through FIFO and flags the program's terminating store.
module store_log_fifo #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] DONE_ADDR = 32'd100,
  parameter logic [31:0] DONE_DATA = 32'd7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWrite,
  input  logic [31:0]                ALUResult,
  input  logic [31:0]                WriteData,
  input  logic [3:0]                 ALUFlags,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [31:0]                rd_addr,
  output logic [31:0]                rd_data,
  output logic [3:0]                 rd_flags,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [15:0]                store_total,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Read handshake: an entry transfers on any rising edge where rd_valid && rd_ready;
  // rd_* are held stable while rd_valid && !rd_ready. There is no backpressure on
  // the store side -- a store arriving while full with no pop is dropped.
  logic [67:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [67:0]   head;

  assign pop  = rd_valid && rd_ready;
  assign push = MemWrite && ((count < FULL_CNT) || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      store_total <= '0;
      done        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (MemWrite && !push) overflow <= 1'b1;
      if (MemWrite) store_total <= store_total + 16'd1;
      if (MemWrite && ALUResult == DONE_ADDR && WriteData == DONE_DATA) done <= 1'b1;
    end
  end

  // Storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= {ALUResult, WriteData, ALUFlags};
  end

  assign rd_valid = (count != '0);
  assign head     = mem[rd_ptr];
  assign rd_addr  = rd_valid ? head[67:36] : 32'd0;
  assign rd_data  = rd_valid ? head[35:4]  : 32'd0;
  assign rd_flags = rd_valid ? head[3:0]   : 4'd0;

endmodule

// File: doc/store_log_fifo.md
# store_log_fifo

Captures every data-memory store the single-cycle core emits (MemWrite strobe with ALUResult as address, WriteData as data, ALUFlags as flags) into a small first-word-fall-through FIFO. Entries drain through a valid/ready port. The block sits directly downstream of the core's store bus, beside data memory. It also raises a sticky completion flag when the program's terminating store appears: data DONE_DATA written to DONE_ADDR.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- DONE_ADDR, 32'd100: completion store address.
- DONE_DATA, 32'd7: completion store data.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- MemWrite  in  1  store strobe from the core; one store per cycle while high.
- ALUResult  in  32  store address.
- WriteData  in  32  store data.
- ALUFlags  in  4  core flags (NZCV) at the store.
- rd_ready  in  1  consumer accepts the head entry.
- rd_valid  out  1  head entry present (count != 0).
- rd_addr  out  32  head entry address; 0 when rd_valid=0.
- rd_data  out  32  head entry data; 0 when rd_valid=0.
- rd_flags  out  4  head entry flags; 0 when rd_valid=0.
- count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.
- overflow  out  1  sticky; a store was dropped because the FIFO was full.
- store_total  out  16  stores seen on the bus, accepted or dropped; wraps 16'hFFFF -> 0.
- done  out  1  sticky; the completion store was seen.

## Operation
- push = MemWrite && (count < DEPTH || pop).
- pop = rd_valid && rd_ready.
- Storage: DEPTH x 68-bit registers, holding {addr, data, flags}. Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Occupancy updates:
  - push only: count+1.
  - pop only: count-1.
  - push and pop in the same cycle: count unchanged, both pointers advance.
  - Full with pop and MemWrite in the same cycle: the store is accepted, count stays DEPTH.
  - Full with MemWrite and no pop: the store is dropped, pointers and count are unchanged, overflow<=1.
- rd_ready while empty: no effect, count stays 0, no underflow.
- store_total increments on every MemWrite=1 cycle, including dropped stores.
- done is set when MemWrite && ALUResult==DONE_ADDR && WriteData==DONE_DATA, whether or not the entry is accepted. It stays set until reset.
- Head outputs come combinationally from the storage at the read pointer, gated to zero when empty. No combinational path runs from MemWrite/ALUResult/WriteData to rd_*.
- Any X on MemWrite is a bench error. The block does not need to handle it.

## Timing
- Reset (sync, checked at rising edge) clears pointers, count, overflow, store_total and done, so every output is 0 the cycle after.
- Storage contents are not reset.
- A reset asserted mid-stream wins over a simultaneous push or pop; that store is neither captured nor counted.
- Latency: a store at edge N appears at the head after edge N when the FIFO was empty, so rd_valid=1 from N through N+1.
- done, overflow, count and store_total reflect edge N's events immediately after edge N.
- Handshake: an entry transfers on any edge where rd_valid && rd_ready. The consumer may hold rd_ready high continuously. rd_* stay stable while rd_valid && !rd_ready.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Reset then idle: hold reset 2 cycles, release, hold MemWrite=0 for 5 cycles -> all outputs 0 throughout.
- Single store: MemWrite=1, ALUResult=0x54, WriteData=0x0000_0011, ALUFlags=4'b0100 for one cycle, rd_ready=0 -> next cycle rd_valid=1, rd_addr=0x54, rd_data=0x11, rd_flags=4'b0100, count=1, store_total=1. Assert rd_ready one cycle -> count=0, rd_* = 0.
- Fill and overflow (DEPTH=8): 9 consecutive stores with data 1..9, rd_ready=0 -> count=8, overflow=1, store_total=9. Drain with rd_ready=1 -> data 1..8 in order, data 9 never appears.
- Full with simultaneous pop and push: FIFO full, one cycle with MemWrite=1 (data 0xAA) and rd_ready=1 -> count stays 8, overflow stays 0, 0xAA drains as the eighth entry after the seven remaining.
- Completion: store data 7 to address 100 -> done=1 the next cycle and held. A store of data 7 to address 104, or data 8 to address 100, leaves done=0. Reset clears done.
- Wrap and reset mid-operation: 20 interleaved pushes and pops with random rd_ready -> order is preserved across pointer wrap. Asserting reset with 3 entries queued and MemWrite=1 -> count=0, store_total=0, rd_valid=0 the next cycle.
